rom_dl_sequencer: RTL and testbench

Sits between data_io and the galaxian core's download port (I_DL_ADDR/I_DL_WR/I_DL_DATA) in the Calypso top.
- Buffers ioctl ROM bytes in a small FIFO and paces them into the core with a ready/write handshake.
- Captures the core_mod byte that selects the hardware variant.
- Holds the game core in reset during download, while buffered bytes drain, and for a fixed settle time after, so the core never runs on a partial ROM image.

---
 rtl/rom_dl_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_rom_dl_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_dl_sequencer.sv
// ROM download sequencer between data_io and the galaxian core download port.
// Define ROM_DL_CHECKSUM_EN to add the rom_sum output (sum of bytes written to the core).
module rom_dl_sequencer #(
  parameter int FIFO_DEPTH  = 8,
  parameter int ROM_SIZE    = 65536,
  parameter int HOLD_CYCLES = 1024
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        rst_req,
  input  logic        dl_ready,
  output logic [15:0] dl_addr,
  output logic [7:0]  dl_data,
  output logic        dl_wr,
  output logic [6:0]  core_mod,
  output logic        core_reset,
  output logic        overflow,
`ifdef ROM_DL_CHECKSUM_EN
  output logic [15:0] rom_sum,
`endif
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [31:0]   ROM_LIMIT = 32'(ROM_SIZE);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          dl_prev;
  logic          dl_rise;

  logic [23:0]   mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          empty;
  logic          full;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          drop;

  assign dl_rise  = ioctl_download & ~dl_prev;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_req = ioctl_download & ioctl_wr & (ioctl_index == 8'd0) &
                    ({7'd0, ioctl_addr} < ROM_LIMIT);
  assign pop      = ~empty & dl_ready;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_prev <= 1'b0;
    end else begin
      dl_prev <= ioctl_download;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {ioctl_addr[15:0], ioctl_dout};
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_wr   <= 1'b0;
      dl_addr <= '0;
      dl_data <= '0;
    end else begin
      dl_wr <= pop;
      if (pop) begin
        {dl_addr, dl_data} <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  // A drop in the same cycle as a new download start still leaves the flag set.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (dl_rise) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      core_mod <= '0;
    end else if (ioctl_download && ioctl_wr && (ioctl_index == 8'd1) &&
                 (ioctl_addr == 25'd0)) begin
      core_mod <= ioctl_dout[6:0];
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_RUN: begin
        if (dl_rise) begin
          state_next = ST_LOAD;
        end else if (rst_req) begin
          state_next = ST_HOLD;
          cnt_next   = HOLD_LOAD;
        end
      end
      ST_LOAD: begin
        if (!ioctl_download) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Wait for the last write to reach the core before starting the settle time.
        if (ioctl_download) begin
          state_next = ST_LOAD;
        end else if (empty && !dl_wr) begin
          state_next = ST_HOLD;
          cnt_next   = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (ioctl_download) begin
          state_next = ST_LOAD;
        end else if (rst_req) begin
          cnt_next = HOLD_LOAD;
        end else if (cnt == '0) begin
          state_next = ST_RUN;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      default: begin
        state_next = ST_HOLD;
        cnt_next   = HOLD_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_HOLD;
      cnt   <= HOLD_LOAD;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  assign core_reset = (state != ST_RUN);
  assign busy       = (state != ST_RUN);

`ifdef ROM_DL_CHECKSUM_EN
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rom_sum <= '0;
    end else if (dl_rise) begin
      rom_sum <= '0;
    end else if (dl_wr && (state != ST_RUN)) begin
      rom_sum <= rom_sum + {8'd0, dl_data};
    end
  end
`endif

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Directed bench for rom_dl_sequencer: FIFO pacing, overflow, core_mod capture and reset hold timing.
module tb_rom_dl_sequencer;

  localparam int H     = 16;
  localparam int DEPTH = 8;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        rst_req;
  logic        dl_ready;
  logic [15:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_wr;
  logic [6:0]  core_mod;
  logic        core_reset;
  logic        overflow;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [23:0] pulse_q[$];
  int          pulse_cyc[$];

  rom_dl_sequencer #(
    .FIFO_DEPTH (DEPTH),
    .ROM_SIZE   (65536),
    .HOLD_CYCLES(H)
  ) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .ioctl_download(ioctl_download),
    .ioctl_index   (ioctl_index),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .rst_req       (rst_req),
    .dl_ready      (dl_ready),
    .dl_addr       (dl_addr),
    .dl_data       (dl_data),
    .dl_wr         (dl_wr),
    .core_mod      (core_mod),
    .core_reset    (core_reset),
    .overflow      (overflow),
    .busy          (busy)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Every write strobe seen by the core, with the cycle it appeared in.
  always @(negedge clk_sys) begin
    if (dl_wr === 1'b1) begin
      pulse_q.push_back({dl_addr, dl_data});
      pulse_cyc.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] idx, input logic [24:0] addr,
                               input logic [7:0] data);
    ioctl_index = idx;
    ioctl_addr  = addr;
    ioctl_dout  = data;
    ioctl_wr    = 1'b1;
    tick(1);
    ioctl_wr    = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic waitCoreResetLow(input int max, output int n);
    n = 0;
    while (core_reset === 1'b1 && n < max) begin
      n++;
      tick(1);
    end
  endtask

  initial begin
    int n;
    int hi;
    int base;
    int push_at[16];
    logic [7:0] d;

    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = 8'd0;
    rst_req        = 1'b0;
    dl_ready       = 1'b0;
    #22;
    checkOutput("rst core_reset", 32'(core_reset), 32'd1);
    checkOutput("rst busy", 32'(busy), 32'd1);
    checkOutput("rst dl_wr", 32'(dl_wr), 32'd0);
    checkOutput("rst dl_addr", 32'(dl_addr), 32'd0);
    checkOutput("rst dl_data", 32'(dl_data), 32'd0);
    checkOutput("rst core_mod", 32'(core_mod), 32'd0);
    checkOutput("rst overflow", 32'(overflow), 32'd0);

    // Reset release: HOLD for exactly H cycles, then RUN.
    @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    waitCoreResetLow(4 * H, n);
    checkOutput("boot hold length", 32'(n), 32'(H));
    checkOutput("boot busy low", 32'(busy), 32'd0);
    checkOutput("boot no dl_wr", 32'(pulse_q.size()), 32'd0);

    // 16-byte burst with the core always ready.
    dl_ready       = 1'b1;
    ioctl_download = 1'b1;
    tick(1);
    base = pulse_q.size();
    for (int i = 0; i < 16; i++) begin
      push_at[i] = cyc;
      applyStimulus(8'd0, 25'(i), 8'(i) ^ 8'hA5);
    end
    tick(2);
    checkOutput("burst pulse count", 32'(pulse_q.size() - base), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (base + i < pulse_q.size()) begin
        d = 8'(i) ^ 8'hA5;
        checkOutput("burst addr/data", 32'(pulse_q[base + i]), 32'({16'(i), d}));
        checkOutput("burst latency", 32'(pulse_cyc[base + i]), 32'(push_at[i] + 2));
      end
    end
    checkOutput("burst overflow", 32'(overflow), 32'd0);
    // One cycle for LOAD to see the fall, one DRAIN cycle, then H HOLD cycles.
    ioctl_download = 1'b0;
    waitCoreResetLow(4 * H, n);
    checkOutput("burst hold length", 32'(n), 32'(H + 2));

    // Same burst while the core stalls: only the first DEPTH bytes survive.
    dl_ready       = 1'b0;
    ioctl_download = 1'b1;
    tick(1);
    base = pulse_q.size();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(8'd0, 25'(i), 8'(i) ^ 8'hA5);
    end
    tick(1);
    checkOutput("stall overflow set", 32'(overflow), 32'd1);
    checkOutput("stall no pulses", 32'(pulse_q.size() - base), 32'd0);
    ioctl_download = 1'b0;
    tick(1);
    dl_ready = 1'b1;
    tick(12);
    checkOutput("stall pulse count", 32'(pulse_q.size() - base), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      if (base + i < pulse_q.size()) begin
        d = 8'(i) ^ 8'hA5;
        checkOutput("stall addr/data", 32'(pulse_q[base + i]), 32'({16'(i), d}));
      end
    end
    checkOutput("stall overflow sticky", 32'(overflow), 32'd1);

    // New download mid-HOLD clears overflow; full FIFO with simultaneous push/pop.
    dl_ready       = 1'b0;
    ioctl_download = 1'b1;
    tick(1);
    checkOutput("overflow cleared", 32'(overflow), 32'd0);
    base = pulse_q.size();
    for (int k = 0; k < DEPTH; k++) begin
      applyStimulus(8'd0, 25'(32 + k), 8'(32 + k) ^ 8'hA5);
    end
    dl_ready = 1'b1;
    applyStimulus(8'd0, 25'h28, 8'h28 ^ 8'hA5);
    dl_ready = 1'b0;
    checkOutput("full push+pop no drop", 32'(overflow), 32'd0);
    applyStimulus(8'd0, 25'h29, 8'h29 ^ 8'hA5);
    checkOutput("still full drops", 32'(overflow), 32'd1);
    ioctl_download = 1'b0;
    dl_ready       = 1'b1;
    tick(14);
    checkOutput("full pulse count", 32'(pulse_q.size() - base), 32'(DEPTH + 1));
    for (int k = 0; k < DEPTH + 1; k++) begin
      if (base + k < pulse_q.size()) begin
        d = 8'(32 + k) ^ 8'hA5;
        checkOutput("full addr/data", 32'(pulse_q[base + k]), 32'({16'(32 + k), d}));
      end
    end
    waitCoreResetLow(4 * H, n);
    checkOutput("full back to run", 32'(core_reset), 32'd0);

    // core_mod capture and ROM_SIZE boundary.
    ioctl_download = 1'b1;
    tick(1);
    applyStimulus(8'd1, 25'd0, 8'h8D);
    checkOutput("core_mod capture", 32'(core_mod), 32'h0D);
    applyStimulus(8'd1, 25'd1, 8'h33);
    checkOutput("core_mod addr1 ignored", 32'(core_mod), 32'h0D);
    applyStimulus(8'd2, 25'd0, 8'h44);
    checkOutput("core_mod index2 ignored", 32'(core_mod), 32'h0D);
    base = pulse_q.size();
    applyStimulus(8'd0, 25'h10000, 8'h11);
    applyStimulus(8'd0, 25'h1FFFFFF, 8'h22);
    applyStimulus(8'd0, 25'h0FFFF, 8'h5A);
    tick(3);
    checkOutput("range pulse count", 32'(pulse_q.size() - base), 32'd1);
    if (base < pulse_q.size()) begin
      checkOutput("range last byte", 32'(pulse_q[base]), 32'h00FFFF5A);
    end
    ioctl_download = 1'b0;
    waitCoreResetLow(4 * H, n);
    checkOutput("range hold length", 32'(n), 32'(H + 2));

    // rst_req pulse and held rst_req in RUN.
    checkOutput("run before rst_req", 32'(core_reset), 32'd0);
    rst_req = 1'b1;
    tick(1);
    rst_req = 1'b0;
    waitCoreResetLow(4 * H, n);
    checkOutput("rst_req pulse hold", 32'(n), 32'(H));
    rst_req = 1'b1;
    tick(2 * H);
    rst_req = 1'b0;
    waitCoreResetLow(4 * H, n);
    checkOutput("rst_req held hold", 32'(n), 32'(H));

    // Download starting mid-HOLD keeps core_reset high past the old count.
    rst_req = 1'b1;
    tick(1);
    rst_req = 1'b0;
    tick(4);
    ioctl_download = 1'b1;
    hi = 0;
    for (int i = 0; i < H + 4; i++) begin
      tick(1);
      if (core_reset === 1'b1) hi++;
    end
    checkOutput("mid-hold load", 32'(hi), 32'(H + 4));
    ioctl_download = 1'b0;
    waitCoreResetLow(4 * H, n);
    checkOutput("mid-hold release", 32'(n), 32'(H + 2));

    // reset_n asserted mid-DRAIN with bytes still buffered.
    dl_ready       = 1'b0;
    ioctl_download = 1'b1;
    tick(1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(8'd0, 25'(64 + k), 8'(k));
    end
    ioctl_download = 1'b0;
    tick(2);
    dl_ready = 1'b1;
    tick(1);
    dl_ready = 1'b0;
    checkOutput("drain dl_wr before reset", 32'(dl_wr), 32'd1);
    checkOutput("drain dl_addr before reset", 32'(dl_addr), 32'h40);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async dl_wr", 32'(dl_wr), 32'd0);
    checkOutput("async dl_addr", 32'(dl_addr), 32'd0);
    checkOutput("async dl_data", 32'(dl_data), 32'd0);
    checkOutput("async core_reset", 32'(core_reset), 32'd1);
    checkOutput("async busy", 32'(busy), 32'd1);
    checkOutput("async core_mod", 32'(core_mod), 32'd0);
    checkOutput("async overflow", 32'(overflow), 32'd0);
    @(posedge clk_sys);
    #1;
    dl_ready = 1'b1;
    base     = pulse_q.size();
    reset_n  = 1'b1;
    waitCoreResetLow(4 * H, n);
    checkOutput("post-reset hold", 32'(n), 32'(H));
    checkOutput("post-reset fifo empty", 32'(pulse_q.size() - base), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
